// File: rtl/fifo_test_sequencer.sv
// Phase controller for the asymmetric-width FIFO self-check demo: FILL -> DRAIN -> STREAM passes.
// Defining FIFO_SEQ_TIMEOUT_EN adds a FILL/DRAIN watchdog that forces ERROR after TIMEOUT_TICKS cycles.
module fifo_test_sequencer #(
    parameter int SYNC_STAGE    = 2,
    parameter int STREAM_TICKS  = 1024,
    parameter int BLINK_DIV_W   = 20,
    parameter int PASS_W        = 8,
    parameter int TIMEOUT_TICKS = 65535
) (
    input  logic              led_clk,
    input  logic              sys_rst,
    input  logic              pll_lock,
    input  logic              rst_busy,
    input  logic              prog_full,
    input  logic              empty,
    input  logic              rdata_error,
    output logic              wr_run,
    output logic              rd_run,
    output logic [2:0]        phase,
    output logic [PASS_W-1:0] pass_count,
    output logic              seq_error,
    output logic              led_status
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        FILL     = 3'd2,
        DRAIN    = 3'd3,
        STREAM   = 3'd4,
        ERROR    = 3'd7
    } state_t;

    localparam int NUM_ASYNC = 5;
    localparam int TICK_W    = $clog2(STREAM_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STREAM_TICKS - 1);

    if (SYNC_STAGE < 2 || BLINK_DIV_W < 4 || STREAM_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_param_check
        $error("fifo_test_sequencer: parameter out of range");
    end

    logic [NUM_ASYNC-1:0]                 async_in;
    logic [NUM_ASYNC-1:0]                 sync_out;
    logic [SYNC_STAGE-1:0][NUM_ASYNC-1:0] sync_q, sync_d;
    logic                                 lock_s, busy_s, pfull_s, empty_s, rderr_s;

    state_t                 state_q, state_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [PASS_W-1:0]      pass_q, pass_d;
    logic [BLINK_DIV_W-1:0] div_q, div_d;
    logic                   led_q, led_d;
    logic                   wr_q, wr_d, rd_q, rd_d, err_q, err_d;
    logic                   timeout;

    // Stage 0 samples the raw pins; the last stage feeds the state machine.
    assign async_in = {rdata_error, empty, prog_full, rst_busy, pll_lock};
    assign sync_out = sync_q[SYNC_STAGE-1];
    assign lock_s   = sync_out[0];
    assign busy_s   = sync_out[1];
    assign pfull_s  = sync_out[2];
    assign empty_s  = sync_out[3];
    assign rderr_s  = sync_out[4];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGE-2:0], async_in};
    end

`ifdef FIFO_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_TICKS - 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    // Timer value equals cycles already spent in the current FILL/DRAIN visit.
    assign timeout = (state_q == FILL || state_q == DRAIN) && (timer_q == TMR_LAST);

    always_comb begin
        timer_d = '0;
        if ((state_q == FILL || state_q == DRAIN) && state_d == state_q) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && rderr_s) begin
            state_d = ERROR;
        end else if (timeout) begin
            state_d = ERROR;
        end else if ((state_q == WAIT_RDY || state_q == FILL || state_q == DRAIN ||
                      state_q == STREAM) && !lock_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (lock_s)           state_d = WAIT_RDY;
                WAIT_RDY: if (!busy_s)          state_d = FILL;
                FILL:     if (pfull_s)          state_d = DRAIN;
                DRAIN:    if (empty_s)          state_d = STREAM;
                STREAM:   if (tick_q == TICK_LAST) state_d = FILL;
                ERROR:                          state_d = ERROR;
                default:                        state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick_d = '0;
        if (state_q == STREAM && state_d == STREAM) begin
            tick_d = tick_q + 1'b1;
        end

        pass_d = pass_q;
        if (state_q == STREAM && state_d == FILL && !(&pass_q)) begin
            pass_d = pass_q + 1'b1;
        end

        // Outputs decode the next state so they change on the same edge as the state register.
        wr_d  = (state_d == FILL)  || (state_d == STREAM);
        rd_d  = (state_d == DRAIN) || (state_d == STREAM);
        err_d = (state_d == ERROR);

        div_d = div_q + 1'b1;
        led_d = led_q;
        case (state_d)
            FILL, DRAIN, STREAM: if (&div_q) led_d = ~led_q;
            ERROR:               if (&div_q[BLINK_DIV_W-4:0]) led_d = ~led_q;
            default:             led_d = 1'b0;
        endcase
    end

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            tick_q  <= '0;
            pass_q  <= '0;
            div_q   <= '0;
            led_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            pass_q  <= pass_d;
            div_q   <= div_d;
            led_q   <= led_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign phase      = state_q;
    assign wr_run     = wr_q;
    assign rd_run     = rd_q;
    assign seq_error  = err_q;
    assign pass_count = pass_q;
    assign led_status = led_q;

endmodule
